// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;

    // Default opcode (instr[15:12]) that stops fetching.
    localparam logic [OPC_W-1:0] HLT_OPCODE_DEF = 4'hF;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // IDLE: one margin cycle after reset; RUN: fetching; HALT: parked after HLT.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // True when the word carries the halt opcode in its top nibble.
    function automatic logic is_hlt(input instr_t word, input logic [OPC_W-1:0] opc);
        return word[INSTR_W-1:INSTR_W-OPC_W] == opc;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular fetch buffer: push/pop/flush with count and a combinational head.
// Flush wins over push and pop in the same cycle.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // Qualify requests: pop needs data, push needs space (or a same-cycle pop).
    always_comb begin
        w_do_pop  = i_pop && (r_count != '0) && !i_flush;
        w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
    end

    // Storage, pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_do_push && !w_do_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_do_push && w_do_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    // Head and status straight from the registers.
    always_comb begin
        o_head  = r_mem[r_rd_ptr];
        o_count = r_count;
        o_full  = (r_count == CNT_W'(DEPTH));
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory (data valid
// before the next rising edge), buffers {instr, pc+1} for decode, handles
// branch redirect/flush and parks after a HLT opcode.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter addr_t            RESET_VECTOR = 16'h0000,
    parameter int               BUF_DEPTH    = 2,
    parameter logic [OPC_W-1:0] HLT_OPCODE   = HLT_OPCODE_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    output addr_t        instr_addr,
    output logic         instr_rd_en,
    input  instr_t       instr,
    input  logic         br_taken,
    input  addr_t        br_target,
    output logic         if_valid,
    output instr_t       if_instr,
    output addr_t        if_pc_plus1,
    input  logic         id_ready,
    output logic         halted
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e                  r_state;
    fetch_state_e                  w_state_next;
    addr_t                         r_pc;
    addr_t                         w_pc_plus1;
    logic                          w_rd_en;
    logic                          w_pop;
    logic                          w_full;
    logic [CNT_W-1:0]              w_count;
    logic [INSTR_W+ADDR_W-1:0]     w_head;

    // Handshake and fetch decision; a redirect suppresses both fetch and pop.
    always_comb begin
        w_pc_plus1 = r_pc + 16'd1;
        w_pop      = (w_count != '0) && id_ready && !br_taken;
        w_rd_en    = (r_state == ST_RUN) && !br_taken && (!w_full || w_pop);
    end

    // Next-state logic; redirect always lands in RUN.
    always_comb begin
        w_state_next = r_state;
        if (br_taken) begin
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_RUN;
                ST_RUN:  if (w_rd_en && is_hlt(instr, HLT_OPCODE)) w_state_next = ST_HALT;
                ST_HALT: w_state_next = ST_HALT;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC: redirect has priority, otherwise advance on every fetch (16-bit wrap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VECTOR;
        end else if (br_taken) begin
            r_pc <= br_target;
        end else if (w_rd_en) begin
            r_pc <= w_pc_plus1;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rd_en),
        .i_pop   (w_pop),
        .i_flush (br_taken),
        .i_wdata ({instr, w_pc_plus1}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

    // Outputs toward memory and decode.
    always_comb begin
        instr_addr  = r_pc;
        instr_rd_en = w_rd_en;
        if_valid    = (w_count != '0);
        if_instr    = w_head[INSTR_W+ADDR_W-1:ADDR_W];
        if_pc_plus1 = w_head[ADDR_W-1:0];
        halted      = (r_state == ST_HALT) && (w_count == '0);
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the PC and drives address/read-enable into instruction memory.
- Memory latches on clock low, so the word for the current address is valid before the next rising edge.
- Captures returned words, with PC+1, into a small buffer. Presents them to decode through a valid/ready handshake.
- Handles branch redirect/flush and stops fetching after a HLT opcode.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- BUF_DEPTH, 2, fetch buffer entries; legal values 2 or 4.
- HLT_OPCODE, 4'hF, value of instr[15:12] that marks a halt instruction.

Ports:
- clk  in  1  system clock; instruction memory reads during the low phase.
- rst_n  in  1  asynchronous active-low reset.
- instr_addr  out  16  address to instruction memory; equals pc.
- instr_rd_en  out  1  read enable to instruction memory.
- instr  in  16  memory read data; sampled at the rising edge that ends the cycle.
- br_taken  in  1  redirect request from execute.
- br_target  in  16  redirect PC, valid when br_taken=1.
- if_valid  out  1  buffer head holds a valid instruction.
- if_instr  out  16  instruction at buffer head.
- if_pc_plus1  out  16  PC+1 of the instruction at buffer head.
- id_ready  in  1  decode accepts the head this cycle.
- halted  out  1  fetch stopped on HLT and buffer drained.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VECTOR, state=IDLE, buffer count=0, all buffer entries cleared.
  - if_valid=0, instr_rd_en=0, halted=0.
  - if_instr and if_pc_plus1 read 0.
- State machine:
  - IDLE: rd_en=0. Goes to RUN on the first rising edge after reset is released. This provides one cycle of margin after reset release.
  - RUN: fetches.
  - HALT: no fetch. Stays in HALT until br_taken or reset.
- Address path: instr_addr=pc, combinational from the pc register.
- Read enable and capture:
  - instr_rd_en=1 iff state==RUN and br_taken==0 and (count<BUF_DEPTH or a pop occurs this cycle).
  - A cycle with instr_rd_en=1 is a fetch. At its rising edge, push {instr, pc+1} and set pc<=pc+1.
  - Single-cycle fetch latency: address in cycle N, word enters the buffer at the end of N, visible on if_* in N+1.
- PC arithmetic: 16-bit modulo; pc=16'hFFFF increments to 16'h0000 with no flag.
- Pop: occurs when if_valid&&id_ready. Head advances at the rising edge. Push and pop in the same cycle leave count unchanged.
- Buffer: circular, with rd/wr pointers and count. if_valid=(count!=0). if_instr and if_pc_plus1 come combinationally from the head entry.
- Full buffer with no pop: rd_en=0 and pc holds.
- HLT detection: a fetched word with instr[15:12]==HLT_OPCODE is pushed normally, pc still increments, and state goes to HALT.
- halted=1 iff state==HALT and count==0.
- Redirect (br_taken=1), highest priority:
  - In the same cycle: rd_en=0, no push; a pop handshake is ignored.
  - At the rising edge: buffer flushed (count=0, pointers reset), pc<=br_target, state<=RUN. This applies from RUN or HALT; from IDLE the state still goes to RUN.
  - The target word is fetched in the next cycle; if_valid rises 2 cycles after br_taken.
- Back-to-back br_taken: the last one wins; each one flushes.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Decomposition:
- Shared package: fetch state enum (IDLE, RUN, HALT); HLT_OPCODE; 16-bit address/instruction widths.
- One sub-module, fetch_buffer: parameterised FIFO with push/pop/flush, count, and head outputs.
- The FSM and PC stay in instr_fetch_unit.

Test Plan:
- Reset then run with id_ready=1, memory preloaded with 0x1000+i at address i:
  - rd_en=0 in cycle 0.
  - addr 0,1,2... from cycle 1.
  - if_instr=0x1000 with if_pc_plus1=0x0001 in cycle 2, then one word per cycle.
- Backpressure: id_ready=0 for 4 cycles.
  - After BUF_DEPTH fetches, rd_en=0 and addr holds.
  - if_instr stays stable.
  - On id_ready=1, fetch resumes with no word lost or duplicated.
- Redirect: br_taken=1, br_target=0x0040 while the buffer holds 2 entries.
  - Next cycle if_valid=0 and addr=0x0040.
  - The following cycle if_instr=mem[0x40] and if_pc_plus1=0x0041.
- Halt: mem[5]=0xF000.
  - After addr 5 is fetched, rd_en=0 and pc=6.
  - halted=1 once the buffer drains.
  - br_taken with br_target=0x0010 clears halted and resumes fetch at 0x0010.
- Wrap: redirect to 0xFFFF. Fetch gives if_pc_plus1=0x0000 and the next addr is 0x0000.
- Async reset asserted mid-low-phase with a full buffer: outputs clear immediately, and addr=RESET_VECTOR.
